// File: rtl/cmd_pkg.sv
// Shared types and constants for the CMD loader to RAM bridge.
package cmd_pkg;

    // Drain sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Width of the optional running checksum
    localparam int CSUM_W = 8;

endpackage

// File: rtl/cmd_ram_bridge_if.sv
// RAM port bus between the bridge (master) and the RAM arbiter (slave).
interface cmd_ram_bridge_if #(
    parameter int ADDR = 16,
    parameter int DATA = 8
);
    logic            ram_req;
    logic            ram_gnt;
    logic            ram_we;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_data;

    modport master (
        output ram_req,
        output ram_we,
        output ram_addr,
        output ram_data,
        input  ram_gnt
    );

    modport slave (
        input  ram_req,
        input  ram_we,
        input  ram_addr,
        input  ram_data,
        output ram_gnt
    );
endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding {addr,data} write entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the registered full flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == FULL_CNT);
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/cmd_ram_bridge.sv
// Bridges the CMD loader write stream into a shared RAM port: writes are
// queued in a FIFO and drained one per grant; the end of a download is
// reported with a done pulse once the queue is empty, along with any
// captured execute vector.
// Optional feature: define CMD_BRIDGE_CHECKSUM_EN to add a modulo-256 sum
// of all data written to RAM on the checksum output.
module cmd_ram_bridge
    import cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADDR  = 16,
    parameter int DATA  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_wr,
    input  logic [ADDR-1:0]  in_addr,
    input  logic [DATA-1:0]  in_data,
    input  logic             in_download,
    input  logic             in_exec_en,
    input  logic [ADDR-1:0]  in_exec_addr,
    output logic             full,
    output logic             cpu_hold,
    cmd_ram_bridge_if.master ram,
    output logic             done,
    output logic             exec_pending,
    output logic [ADDR-1:0]  exec_vector,
    output logic             overflow
`ifdef CMD_BRIDGE_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] checksum
`endif
);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WIDTH = ADDR + DATA;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             download_q;
    logic             dl_rise;
    logic             dl_fall;
    logic             end_seen;
    logic             exec_captured;

    assign push    = in_wr & ~fifo_full;
    assign full    = fifo_full;
    assign dl_rise = in_download & ~download_q;
    assign dl_fall = ~in_download & download_q;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({in_addr, in_data}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full)
    );

    // Drain sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Drain sequencer transitions and RAM port outputs
    always_comb begin
        state_next   = state;
        ram.ram_req  = 1'b0;
        ram.ram_we   = 1'b0;
        ram.ram_addr = '0;
        ram.ram_data = '0;
        pop          = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0)
                    state_next = ST_REQ;
                else if (end_seen && !push)
                    state_next = ST_FINISH;
            end
            ST_REQ: begin
                ram.ram_req = 1'b1;
                if (ram.ram_gnt) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                ram.ram_req                  = 1'b1;
                ram.ram_we                   = 1'b1;
                {ram.ram_addr, ram.ram_data} = head;
                pop                          = 1'b1;
                // Entries left after this pop (including one arriving now)
                state_next = ((count > CW'(1)) || push) ? ST_REQ : ST_IDLE;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Download edge tracking, end-of-load flag and registered CPU hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            download_q <= 1'b0;
            end_seen   <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            download_q <= in_download;
            cpu_hold   <= in_download | (count != '0) | (state != ST_IDLE);
            if (dl_rise)
                end_seen <= 1'b0;
            else if (dl_fall)
                end_seen <= 1'b1;
            else if (state == ST_FINISH)
                end_seen <= 1'b0;
        end
    end

    // Sticky overflow: set on a dropped write, cleared when a new download starts
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (in_wr && fifo_full)
            overflow <= 1'b1;
        else if (dl_rise)
            overflow <= 1'b0;
    end

    // Execute vector capture; the most recent strobe wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exec_vector   <= '0;
            exec_captured <= 1'b0;
        end else if (in_exec_en) begin
            exec_vector   <= in_exec_addr;
            exec_captured <= 1'b1;
        end else if (dl_rise) begin
            exec_captured <= 1'b0;
        end
    end

    // Execute pending flag raised at the end of a drained load
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            exec_pending <= 1'b0;
        else if (dl_rise)
            exec_pending <= 1'b0;
        else if (state == ST_FINISH && exec_captured)
            exec_pending <= 1'b1;
    end

`ifdef CMD_BRIDGE_CHECKSUM_EN
    // Running modulo-256 sum of every byte written to RAM
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (dl_rise)
            checksum <= '0;
        else if (ram.ram_we)
            checksum <= checksum + CSUM_W'(ram.ram_data);
    end
`endif
endmodule

// File: tb/tb_cmd_ram_bridge.sv
// Scoreboard testbench for cmd_ram_bridge (DEPTH=8, ADDR=16, DATA=8).
module tb_cmd_ram_bridge;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_wr;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        in_download;
    logic        in_exec_en;
    logic [15:0] in_exec_addr;
    logic        full;
    logic        cpu_hold;
    logic        done;
    logic        exec_pending;
    logic [15:0] exec_vector;
    logic        overflow;
`ifdef CMD_BRIDGE_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int checks     = 0;
    int errors     = 0;
    int we_count   = 0;
    int done_count = 0;
    logic [31:0] sb[$];

    always #5 clock = ~clock;

    cmd_ram_bridge_if #(.ADDR(16), .DATA(8)) ram_bus ();

    cmd_ram_bridge #(.DEPTH(8), .ADDR(16), .DATA(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_wr        (in_wr),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_download  (in_download),
        .in_exec_en   (in_exec_en),
        .in_exec_addr (in_exec_addr),
        .full         (full),
        .cpu_hold     (cpu_hold),
        .ram          (ram_bus),
        .done         (done),
        .exec_pending (exec_pending),
        .exec_vector  (exec_vector),
        .overflow     (overflow)
`ifdef CMD_BRIDGE_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input logic [15:0] a, input logic [7:0] d, input bit accept);
        in_wr   = 1'b1;
        in_addr = a;
        in_data = d;
        if (accept) sb.push_back({8'h00, a, d});
        step();
        in_wr = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((sb.size() != 0 || ram_bus.ram_req) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(n), 32'd0);
    endtask

    // Scoreboard monitor: every RAM write must match the oldest accepted entry
    always @(negedge clock) begin
        if (!reset) begin
            if (done) done_count++;
            if (ram_bus.ram_we) begin
                we_count++;
                if (sb.size() == 0)
                    check("we_unexpected", 32'd1, 32'd0);
                else
                    check("we_entry", {8'h00, ram_bus.ram_addr, ram_bus.ram_data}, sb.pop_front());
            end
        end
    end

    initial begin
        int base_we;
        int base_done;
        int good;
        bit seen;

        reset = 1'b1;
        in_wr = 1'b0; in_addr = '0; in_data = '0;
        in_download = 1'b0; in_exec_en = 1'b0; in_exec_addr = '0;
        ram_bus.ram_gnt = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_full",     32'(full),            32'd0);
        check("rst_cpu_hold", 32'(cpu_hold),        32'd0);
        check("rst_ram_req",  32'(ram_bus.ram_req), 32'd0);
        check("rst_ram_we",   32'(ram_bus.ram_we),  32'd0);
        check("rst_done",     32'(done),            32'd0);
        check("rst_exec_pend",32'(exec_pending),    32'd0);
        check("rst_overflow", 32'(overflow),        32'd0);
        check("rst_ram_addr", 32'(ram_bus.ram_addr),32'd0);
        check("rst_ram_data", 32'(ram_bus.ram_data),32'd0);
        check("rst_exec_vec", 32'(exec_vector),     32'd0);
        reset = 1'b0;
        step();

        // Single write with grant tied high
        ram_bus.ram_gnt = 1'b1;
        write_entry(16'h4200, 8'hA5, 1'b1);
        check("single_req_n",   32'(ram_bus.ram_req), 32'd0);
        step();
        check("single_req_n1",  32'(ram_bus.ram_req), 32'd1);
        check("single_we_n1",   32'(ram_bus.ram_we),  32'd0);
        step();
        check("single_we_n2",   32'(ram_bus.ram_we),  32'd1);
        check("single_addr_n2", 32'(ram_bus.ram_addr),32'h4200);
        check("single_data_n2", 32'(ram_bus.ram_data),32'hA5);
        wait_idle();

        // Burst of 9 into an 8-deep FIFO with grant withheld
        ram_bus.ram_gnt = 1'b0;
        base_we = we_count;
        for (int i = 0; i < 9; i++) begin
            write_entry(16'h1000 + 16'(i), 8'(i * 17 + 3), i < 8);
            if (i == 7) check("burst_full_after8", 32'(full), 32'd1);
        end
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_no_we",    32'(we_count - base_we), 32'd0);
        ram_bus.ram_gnt = 1'b1;
        wait_idle();
        repeat (2) step();
        check("burst_we_total", 32'(we_count - base_we), 32'd8);
        check("burst_full_clr", 32'(full), 32'd0);

        // Grant held low for 5 cycles
        ram_bus.ram_gnt = 1'b0;
        write_entry(16'h2222, 8'h3C, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ram_bus.ram_req) seen = 1'b1;
            else step();
        end
        check("stall_req_seen", 32'(seen), 32'd1);
        base_we = we_count;
        good = 0;
        for (int i = 0; i < 5; i++) begin
            if (ram_bus.ram_req && !ram_bus.ram_we) good++;
            step();
        end
        check("stall_req_held", 32'(good), 32'd5);
        ram_bus.ram_gnt = 1'b1;
        repeat (6) step();
        check("stall_one_we", 32'(we_count - base_we), 32'd1);

        // Download with execute vector, end of load while 3 entries queued
        ram_bus.ram_gnt = 1'b0;
        in_download = 1'b1;
        repeat (2) step();
        check("dl_rise_clr_ovf", 32'(overflow), 32'd0);
        in_exec_en = 1'b1; in_exec_addr = 16'h1111;
        step();
        in_exec_addr = 16'h5200;
        step();
        in_exec_en = 1'b0;
        write_entry(16'h3000, 8'h11, 1'b1);
        write_entry(16'h3001, 8'h22, 1'b1);
        write_entry(16'h3002, 8'h33, 1'b1);
        in_download = 1'b0;
        base_done = done_count;
        repeat (4) step();
        check("exec_no_early_done", 32'(done_count - base_done), 32'd0);
        base_we = we_count;
        ram_bus.ram_gnt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("exec_done_seen",   32'(seen), 32'd1);
        check("exec_we_at_done",  32'(we_count - base_we), 32'd3);
        step();
        check("exec_done_pulse",  32'(done), 32'd0);
        check("exec_pending",     32'(exec_pending), 32'd1);
        check("exec_vector",      32'(exec_vector), 32'h5200);
        step();
        check("exec_cpu_hold_off",32'(cpu_hold), 32'd0);

        // Reset with 4 entries queued
        ram_bus.ram_gnt = 1'b0;
        in_download = 1'b1;
        repeat (2) step();
        check("dl_rise_clr_pend", 32'(exec_pending), 32'd0);
        write_entry(16'h4000, 8'h01, 1'b0);
        write_entry(16'h4001, 8'h02, 1'b0);
        write_entry(16'h4002, 8'h03, 1'b0);
        write_entry(16'h4003, 8'h04, 1'b0);
        reset = 1'b1;
        in_download = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        base_we = we_count;
        base_done = done_count;
        ram_bus.ram_gnt = 1'b1;
        repeat (10) step();
        check("rst_mid_no_we",   32'(we_count - base_we), 32'd0);
        check("rst_mid_no_done", 32'(done_count - base_done), 32'd0);
        check("rst_mid_count",   32'(dut.count), 32'd0);
        check("rst_mid_cpu_hold",32'(cpu_hold), 32'd0);
        check("rst_mid_full",    32'(full), 32'd0);

`ifdef CMD_BRIDGE_CHECKSUM_EN
        // Checksum wraps modulo 256
        in_download = 1'b1;
        repeat (2) step();
        ram_bus.ram_gnt = 1'b1;
        write_entry(16'h5000, 8'hFF, 1'b1);
        write_entry(16'h5001, 8'h02, 1'b1);
        wait_idle();
        step();
        check("checksum", 32'(checksum), 32'h01);
`endif

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "time limit");
    end
endmodule
